multi_timer: RTL
================

Name: multi_timer

Overview:
- Multi-channel, parametrised successor to the single free-running seconds timer.
- One shared prescaler divides clk into a tick; N_CH independent channels count ticks.
- Each channel has run/pause/clear control, a programmable limit and a sticky expired flag.
- Sits beside game/control logic as the common time base for countdowns, timeouts and elapsed-time displays.

Parameters:
- N_CH, 4, number of independent timer channels (>=1).
- TIMER_WIDTH, 16, width of each channel count and limit.
- TICK_DIV, 100_000_000, clk cycles per tick (>=2); default gives 1 s at 100 MHz.
- CH_W, $clog2(N_CH) (min 1), width of the channel index, derived, not for override.

Ports:
- clk  in  1  clock.
- rst_n  in  1  asynchronous, active-low reset.
- i_cmd_valid  in  1  command strobe; one command per cycle, always accepted.
- i_cmd_ch  in  CH_W  target channel; index >= N_CH is ignored.
- i_cmd_op  in  2  0=START, 1=PAUSE, 2=CLEAR, 3=SET_LIMIT.
- i_cmd_data  in  TIMER_WIDTH  limit value, used by SET_LIMIT only.
- o_tick  out  1  one-cycle pulse, registered, one per TICK_DIV cycles.
- o_time  out  N_CH*TIMER_WIDTH  packed counts, channel k at [k*W +: W].
- o_running  out  N_CH  1 when the channel is in RUN.
- o_expired  out  N_CH  sticky; set on reaching the limit.

Behaviour:
- Reset, asynchronous: prescaler=0, all counts=0, limits=0, all channels IDLE; o_tick, o_running, o_expired = 0.
- Prescaler counts 0..TICK_DIV-1. The edge where it equals TICK_DIV-1 is the tick edge: prescaler returns to 0 and every RUN channel increments.
- o_tick is high for the cycle after the tick edge, coincident with the updated counts. The period is exactly TICK_DIV cycles, with no off-by-one.
- Channel FSM states: IDLE, RUN, PAUSED, DONE.
  - START: IDLE/PAUSED -> RUN, count kept. No-op in RUN or DONE.
  - PAUSE: RUN -> PAUSED. No-op otherwise.
  - CLEAR: any state -> IDLE, count=0, expired=0. Limit is kept.
  - SET_LIMIT: limit <= i_cmd_data; state and count unchanged.
- Limit=0 means unlimited: the count wraps from 2^W-1 to 0 silently, and expired is never set.
- Limit L>0, on a tick edge in RUN with count+1 == L: count=L, state -> DONE, expired=1. Later ticks leave the count unchanged.
- If a SET_LIMIT writes L <= the current count, the channel never matches and runs until wrap. No retroactive expiry.
- Command and tick in the same cycle on the same channel: the command wins.
  - CLEAR gives count 0.
  - PAUSE means no increment.
  - START from IDLE/PAUSED does not increment that cycle.
  - START in RUN is a no-op, and the increment still occurs.
  - SET_LIMIT: this edge's compare uses the old limit; the new limit applies from the next edge.
- Commands never disturb the prescaler phase. Commands to other channels do not interact.
- o_running and o_time are registered, with no combinational path from inputs.

Optional Feature:
- Macro: MULTI_TIMER_AUTORELOAD_EN.
- Defined: on reaching limit L, the channel sets expired (sticky, cleared by CLEAR only), loads count=0 and stays in RUN. DONE is unused.
- Undefined: stop-at-limit behaviour as above.

Decomposition:
- Package multi_timer_pkg holds:
  - typedef enum logic [1:0] cmd_op_t: CMD_START, CMD_PAUSE, CMD_CLEAR, CMD_SET_LIMIT.
  - typedef enum ch_state_t: ST_IDLE, ST_RUN, ST_PAUSED, ST_DONE.
- Sub-module timer_channel: one channel's FSM, count, limit and expired flag. Inputs are tick, a decoded per-channel command valid, op and data.
- Top level holds the prescaler, the o_tick register, command decode and a generate loop over N_CH instances.

Test Plan:
All tests use N_CH=4, TIMER_WIDTH=8, TICK_DIV=4 unless stated.
- Reset, START ch0, wait 40 cycles -> o_tick pulses every 4 cycles; ch0 time=10; other channels 0, not running.
- SET_LIMIT ch1=3, START ch1 -> after 3 ticks: time[1]=3, expired[1]=1, running[1]=0; 5 more ticks leave it at 3; CLEAR -> 0, expired[1]=0.
- START ch2, PAUSE at count 5, wait 20 cycles -> stays 5; START -> 6 after the next tick; CLEAR issued on a tick edge -> 0 and IDLE, no increment.
- Limit 0, run 256 ticks -> ch3 wraps 255 -> 0; expired[3] stays 0.
- Assert rst_n low mid-run with ch0=7 -> all outputs 0 immediately, before the next clk edge; prescaler phase restarts from 0.
- With MULTI_TIMER_AUTORELOAD_EN and limit 3 -> sequence 1,2,0,1,2,0...; expired set at the first wrap; running stays 1.

Source files
------------

// File: rtl/multi_timer_pkg.sv
// Shared types for the multi-channel timer: command opcodes and channel states.
package multi_timer_pkg;

  typedef enum logic [1:0] {
    CMD_START     = 2'd0,
    CMD_PAUSE     = 2'd1,
    CMD_CLEAR     = 2'd2,
    CMD_SET_LIMIT = 2'd3
  } cmd_op_t;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_RUN    = 2'd1,
    ST_PAUSED = 2'd2,
    ST_DONE   = 2'd3
  } ch_state_t;

endpackage

// File: rtl/timer_channel.sv
// One timer channel: run/pause/clear FSM, tick counter, programmable limit and a
// sticky expired flag. Optional macro MULTI_TIMER_AUTORELOAD_EN turns the
// stop-at-limit behaviour into reload-to-zero while staying in RUN.
module timer_channel
  import multi_timer_pkg::*;
#(
  parameter int unsigned TIMER_WIDTH = 16
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   i_tick,
  input  logic                   i_cmd_valid,
  input  cmd_op_t                i_cmd_op,
  input  logic [TIMER_WIDTH-1:0] i_cmd_data,
  output logic [TIMER_WIDTH-1:0] o_time,
  output logic                   o_running,
  output logic                   o_expired
);

  ch_state_t              r_state, w_state_next;
  logic [TIMER_WIDTH-1:0] r_count, w_count_next;
  logic [TIMER_WIDTH-1:0] r_limit, w_limit_next;
  logic                   r_expired, w_expired_next;

  logic                   w_cmd_blocks_inc;
  logic                   w_inc;
  logic [TIMER_WIDTH-1:0] w_count_inc;
  logic                   w_hit;

  // A PAUSE or CLEAR on this edge wins over a tick; START in RUN does not.
  assign w_cmd_blocks_inc = i_cmd_valid && ((i_cmd_op == CMD_PAUSE) || (i_cmd_op == CMD_CLEAR));
  assign w_inc            = i_tick && (r_state == ST_RUN) && !w_cmd_blocks_inc;
  assign w_count_inc      = r_count + TIMER_WIDTH'(1);
  // Limit 0 means unlimited; compare uses the limit held before this edge.
  assign w_hit            = (r_limit != '0) && (w_count_inc == r_limit);

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_state_next;
    end
  end

  // Count, limit and expired registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_count   <= '0;
      r_limit   <= '0;
      r_expired <= 1'b0;
    end else begin
      r_count   <= w_count_next;
      r_limit   <= w_limit_next;
      r_expired <= w_expired_next;
    end
  end

  // Next state: tick increment first, then the command overrides it
  always_comb begin
    w_state_next   = r_state;
    w_count_next   = r_count;
    w_limit_next   = r_limit;
    w_expired_next = r_expired;

    if (w_inc) begin
      if (w_hit) begin
        w_expired_next = 1'b1;
`ifdef MULTI_TIMER_AUTORELOAD_EN
        w_count_next   = '0;
`else
        w_count_next   = r_limit;
        w_state_next   = ST_DONE;
`endif
      end else begin
        w_count_next = w_count_inc;
      end
    end

    if (i_cmd_valid) begin
      unique case (i_cmd_op)
        CMD_START: begin
          if ((r_state == ST_IDLE) || (r_state == ST_PAUSED)) begin
            w_state_next = ST_RUN;
          end
        end
        CMD_PAUSE: begin
          if (r_state == ST_RUN) begin
            w_state_next = ST_PAUSED;
          end
        end
        CMD_CLEAR: begin
          w_state_next   = ST_IDLE;
          w_count_next   = '0;
          w_expired_next = 1'b0;
        end
        CMD_SET_LIMIT: begin
          w_limit_next = i_cmd_data;
        end
      endcase
    end
  end

  // Outputs derive from registers only
  always_comb begin
    o_time    = r_count;
    o_running = (r_state == ST_RUN);
    o_expired = r_expired;
  end

endmodule

// File: rtl/multi_timer.sv
// Multi-channel timer: shared prescaler producing a tick every TICK_DIV cycles,
// command decode and N_CH timer_channel instances. Build option
// MULTI_TIMER_AUTORELOAD_EN selects auto-reload at the limit.
module multi_timer
  import multi_timer_pkg::*;
#(
  parameter int unsigned N_CH        = 4,
  parameter int unsigned TIMER_WIDTH = 16,
  parameter int unsigned TICK_DIV    = 100_000_000,
  localparam int unsigned CH_W       = (N_CH > 1) ? $clog2(N_CH) : 1
) (
  input  logic                        clk,
  input  logic                        rst_n,
  input  logic                        i_cmd_valid,
  input  logic [CH_W-1:0]             i_cmd_ch,
  input  logic [1:0]                  i_cmd_op,
  input  logic [TIMER_WIDTH-1:0]      i_cmd_data,
  output logic                        o_tick,
  output logic [N_CH*TIMER_WIDTH-1:0] o_time,
  output logic [N_CH-1:0]             o_running,
  output logic [N_CH-1:0]             o_expired
);

  localparam int unsigned PW = $clog2(TICK_DIV);
  localparam logic [PW-1:0] PRESC_LAST = PW'(TICK_DIV - 1);

  logic [PW-1:0] r_presc;
  logic          r_tick;
  logic          w_tick_edge;
  cmd_op_t       w_cmd_op;

  assign w_tick_edge = (r_presc == PRESC_LAST);
  assign w_cmd_op    = cmd_op_t'(i_cmd_op);
  assign o_tick      = r_tick;

  // Prescaler and tick pulse; commands never touch the phase
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_presc <= '0;
      r_tick  <= 1'b0;
    end else begin
      r_presc <= w_tick_edge ? '0 : r_presc + PW'(1);
      r_tick  <= w_tick_edge;
    end
  end

  for (genvar k = 0; k < N_CH; k++) begin : g_ch
    logic w_sel;

    // Out-of-range channel indices never match any k
    assign w_sel = i_cmd_valid && (i_cmd_ch == CH_W'(k));

    timer_channel #(
      .TIMER_WIDTH(TIMER_WIDTH)
    ) u_ch (
      .clk        (clk),
      .rst_n      (rst_n),
      .i_tick     (w_tick_edge),
      .i_cmd_valid(w_sel),
      .i_cmd_op   (w_cmd_op),
      .i_cmd_data (i_cmd_data),
      .o_time     (o_time[k*TIMER_WIDTH +: TIMER_WIDTH]),
      .o_running  (o_running[k]),
      .o_expired  (o_expired[k])
    );
  end

endmodule
